// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus collector.
//   state_t  : collector FSM states (IDLE, GRANT)
//   id_width : width of a source index for a given source count
package tri_bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in  [NUM_SOURCES]  request vector
//   ptr     in  [ID_WIDTH]     index searched first; search wraps to 0
//   gnt     out [NUM_SOURCES]  one-hot grant (all zero when no request)
//   gnt_idx out [ID_WIDTH]     index of the granted request
//   any     out                at least one request present
module rr_arbiter import tri_bus_pkg::*; #(
  parameter int unsigned NUM_SOURCES = 40,
  parameter int unsigned ID_WIDTH    = id_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [ID_WIDTH-1:0]    ptr,
  output logic [NUM_SOURCES-1:0] gnt,
  output logic [ID_WIDTH-1:0]    gnt_idx,
  output logic                   any
);

  int unsigned cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      // Candidate index ptr+k, wrapped into 0..NUM_SOURCES-1.
      cand = 32'(ptr) + k;
      if (cand >= NUM_SOURCES) cand = cand - NUM_SOURCES;
      if (!any && req[ID_WIDTH'(cand)]) begin
        any                    = 1'b1;
        gnt[ID_WIDTH'(cand)]   = 1'b1;
        gnt_idx                = ID_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/tri_bus_collector.sv
// Collects words from many sources sharing one tri-state bus into a single
// registered output. One source at a time is granted (bus_en), a word is
// moved per grant, and every grant is followed by a bus-turnaround IDLE cycle.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   src_valid/src_data      per-source request and data word
//   src_ready               per-source accept strobe
//   bus_en                  one-hot-or-zero drive enable of the granted source
//   out_valid/out_data      collected word, held until out_ready
//   out_src_id              index of the source that supplied out_data
//   out_ready               downstream accept
module tri_bus_collector import tri_bus_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_SOURCES = 40,
  parameter int unsigned ID_WIDTH    = id_width(NUM_SOURCES)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_SOURCES-1:0]                src_valid,
  input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_data,
  output logic [NUM_SOURCES-1:0]                src_ready,
  output logic [NUM_SOURCES-1:0]                bus_en,
  output logic                                  out_valid,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [ID_WIDTH-1:0]                   out_src_id,
  input  logic                                  out_ready
);

  state_t                 state_q;
  logic [NUM_SOURCES-1:0] grant_q;
  logic [ID_WIDTH-1:0]    gidx_q;
  logic [ID_WIDTH-1:0]    ptr_q;

  logic [NUM_SOURCES-1:0] arb_gnt;
  logic [ID_WIDTH-1:0]    arb_idx;
  logic                   arb_any;

  logic can_load;
  logic cur_valid;
  logic xfer;

  rr_arbiter #(
    .NUM_SOURCES (NUM_SOURCES),
    .ID_WIDTH    (ID_WIDTH)
  ) u_arb (
    .req     (src_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Output register can take a word when empty or being popped this cycle.
  assign can_load  = !out_valid || out_ready;
  assign cur_valid = src_valid[gidx_q];
  assign xfer      = (state_q == GRANT) && cur_valid && can_load;
  assign src_ready = ((state_q == GRANT) && can_load) ? (grant_q & src_valid) : '0;
  assign bus_en    = grant_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src_id <= '0;
    end else begin
      // A load wins over a pop so a simultaneous pop+load keeps out_valid high.
      if (xfer) begin
        out_valid  <= 1'b1;
        out_data   <= src_data[gidx_q];
        out_src_id <= gidx_q;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!cur_valid) begin
            // Withdrawn request: release the bus, keep the search pointer.
            grant_q <= '0;
            state_q <= IDLE;
          end else if (can_load) begin
            ptr_q   <= (gidx_q == ID_WIDTH'(NUM_SOURCES - 1)) ? '0 : gidx_q + 1'b1;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bus_collector.sv
// Self-checking bench for tri_bus_collector (4 sources, 8-bit data).
// Accepted source handshakes push the expected word into a scoreboard; a
// negedge monitor pops and compares on each output pop and checks grant
// order, turnaround and stall rules against a small reference model.
module tb_tri_bus_collector;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N-1:0]        src_valid;
  logic [N-1:0][W-1:0] src_data;
  logic [N-1:0]        src_ready;
  logic [N-1:0]        bus_en;
  logic                out_valid;
  logic [W-1:0]        out_data;
  logic [IW-1:0]       out_src_id;
  logic                out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tri_bus_collector #(
    .DATA_WIDTH  (W),
    .NUM_SOURCES (N),
    .ID_WIDTH    (IW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .bus_en     (bus_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src_id (out_src_id),
    .out_ready  (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: first requester searching from p upward, wrapping.
  function automatic logic [N-1:0] ref_grant(input logic [N-1:0] v, input int p);
    logic [N-1:0] one;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) begin
        one = '0;
        one[idx] = 1'b1;
        return one;
      end
    end
    return '0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [IW+W-1:0] sb[$];
  logic [IW+W-1:0] mon_e;
  logic [N-1:0]    mon_hs;
  int              mon_id;
  int              mptr;
  bit              prev_rst   = 1'b1;
  bit              prev_xfer  = 1'b0;
  bit              prev_stall = 1'b0;
  logic [N-1:0]    prev_bus   = '0;
  logic [N-1:0]    prev_valid = '0;
  logic [W-1:0]    prev_data;
  logic [IW-1:0]   prev_id;

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      mptr       = 0;
      prev_rst   = 1'b1;
      prev_xfer  = 1'b0;
      prev_stall = 1'b0;
      prev_bus   = '0;
    end else begin
      chk("bus_en_onehot", 32'($countones(bus_en) <= 1), 1);
      chk("src_ready_scope", 32'(src_ready & ~(bus_en & src_valid)), 0);
      if (prev_xfer) chk("turnaround_gap", 32'(bus_en), 0);
      if (!prev_rst && prev_bus == '0 && bus_en != '0)
        chk("grant_order", 32'(bus_en), 32'(ref_grant(prev_valid, mptr)));
      if (prev_bus != '0 && bus_en != '0)
        chk("grant_held", 32'(bus_en), 32'(prev_bus));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_id", 32'(out_src_id), 32'(prev_id));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got id %0d data 0x%0h, expected no word", out_src_id, out_data);
        end else begin
          mon_e = sb.pop_front();
          chk("out_src_id", 32'(out_src_id), 32'(mon_e[IW+W-1:W]));
          chk("out_data", 32'(out_data), 32'(mon_e[W-1:0]));
        end
      end
      mon_hs = src_valid & src_ready;
      if (mon_hs != '0) begin
        mon_id = 0;
        for (int i = 0; i < N; i++) if (mon_hs[i]) mon_id = i;
        sb.push_back({IW'(mon_id), src_data[mon_id]});
        mptr = (mon_id + 1) % N;
      end
      prev_xfer  = (mon_hs != '0);
      prev_rst   = 1'b0;
      prev_bus   = bus_en;
      prev_valid = src_valid;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_id    = out_src_id;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus_en != '0) begin
        g = bus_en;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL grant_timeout: got bus_en 0x%0h expected a grant within 20 cycles", bus_en);
  endtask

  logic [N-1:0] g;
  logic [N-1:0] hs;
  int           order [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset_n   = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("reset_bus_en", 32'(bus_en), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_src_id", 32'(out_src_id), 0);
    chk("reset_src_ready", 32'(src_ready), 0);
    reset_n = 1'b1;

    // Single request: grant at cycle 1, output at cycle 2.
    src_valid   = 4'b0100;
    src_data[2] = 8'hA5;
    step();
    chk("single_bus_en", 32'(bus_en), 32'h4);
    chk("single_src_ready", 32'(src_ready), 32'h4);
    chk("single_no_out_yet", 32'(out_valid), 0);
    step();
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_out_id", 32'(out_src_id), 2);
    chk("single_gap", 32'(bus_en), 0);
    src_valid = '0;
    repeat (2) step();

    // Wrap: pointer is now 3.
    src_valid   = 4'b1001;
    src_data[3] = 8'h33;
    src_data[0] = 8'h3C;
    wait_grant(g);
    chk("wrap_first", 32'(g), 32'h8);
    step();
    chk("wrap_gap", 32'(bus_en), 0);
    chk("wrap_out_id", 32'(out_src_id), 3);
    wait_grant(g);
    chk("wrap_second", 32'(g), 32'h1);
    step();
    chk("wrap_out_data", 32'(out_data), 32'h3C);
    src_valid = '0;
    repeat (2) step();

    // Backpressure: pointer is now 1.
    src_valid   = 4'b0010;
    src_data[1] = 8'h11;
    wait_grant(g);
    chk("bp_setup_grant", 32'(g), 32'h2);
    step();
    out_ready   = 1'b0;
    src_valid   = 4'b0100;
    src_data[2] = 8'h5A;
    wait_grant(g);
    chk("bp_grant", 32'(g), 32'h4);
    chk("bp_src_ready_low", 32'(src_ready), 0);
    repeat (2) step();
    chk("bp_grant_held", 32'(bus_en), 32'h4);
    chk("bp_valid_held", 32'(out_valid), 1);
    chk("bp_data_stable", 32'(out_data), 32'h11);
    chk("bp_id_stable", 32'(out_src_id), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_src_ready_release", 32'(src_ready), 32'h4);
    step();
    chk("bp_reload_valid", 32'(out_valid), 1);
    chk("bp_reload_data", 32'(out_data), 32'h5A);
    chk("bp_reload_id", 32'(out_src_id), 2);
    src_valid = '0;

    // Reset while granted with a held word (pointer is now 3).
    out_ready = 1'b0;
    src_valid = 4'b1000;
    wait_grant(g);
    chk("rst_setup_grant", 32'(g), 32'h8);
    chk("rst_setup_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    step();
    chk("rst_bus_en", 32'(bus_en), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_src_ready", 32'(src_ready), 0);

    // All sources requesting after reset: 0,1,2,3,0 with gaps.
    reset_n   = 1'b1;
    out_ready = 1'b1;
    src_valid = 4'b1111;
    for (int i = 0; i < N; i++) src_data[i] = 8'(8'h80 + i);
    for (int j = 0; j < 5; j++) begin
      wait_grant(g);
      chk("all_req_order", 32'(g), 32'(1) << order[j]);
      step();
      chk("all_req_gap", 32'(bus_en), 0);
      chk("all_req_data", 32'(out_data), 32'(8'h80 + order[j]));
    end
    src_valid = '0;
    repeat (3) step();

    // Withdraw during grant (pointer is now 1).
    src_valid = 4'b0010;
    wait_grant(g);
    chk("wd_grant", 32'(g), 32'h2);
    src_valid = '0;
    step();
    chk("wd_idle", 32'(bus_en), 0);
    chk("wd_no_out", 32'(out_valid), 0);
    step();
    chk("wd_still_no_out", 32'(out_valid), 0);
    src_valid = 4'b1111;
    wait_grant(g);
    chk("wd_ptr_unchanged", 32'(g), 32'h2);
    step();
    src_valid = '0;
    repeat (2) step();

    // Random traffic with sticky requests, occasional withdrawal, backpressure.
    for (int c = 0; c < 3000; c++) begin
      #2;
      hs = src_valid & src_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (!(src_valid[i] && !hs[i] && $urandom_range(9) != 0)) begin
          src_valid[i] = ($urandom_range(1) != 0);
          src_data[i]  = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(3) != 0);
    end

    src_valid = '0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_bus_collector.md
TRI_BUS_COLLECTOR -- requirements
Module: tri_bus_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every source data word and of out_data.
REQ-002 Parameter NUM_SOURCES, default 40: number of drivers sharing the bus, minimum 2.
REQ-003 Parameter ID_WIDTH, default $clog2(NUM_SOURCES): width of out_src_id.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 src_valid  in  [NUM_SOURCES]  per-source request; data valid.
REQ-007 src_data  in  [NUM_SOURCES] x DATA_WIDTH  per-source data word.
REQ-008 src_ready  out  [NUM_SOURCES]  per-source accept strobe; a transfer occurs when src_valid[i] and src_ready[i] are both 1.
REQ-009 bus_en  out  [NUM_SOURCES]  one-hot-or-zero drive enable for the granted source.
REQ-010 out_valid  out  1  collected word available.
REQ-011 out_data  out  DATA_WIDTH  collected word.
REQ-012 out_src_id  out  ID_WIDTH  index of the source that supplied out_data.
REQ-013 out_ready  in  1  downstream accepts out_data when out_valid is 1.

Function
REQ-014 FSM states: IDLE and GRANT; the grant register (grant_q) drives bus_en directly.
REQ-015 IDLE: grant_q = 0; if any src_valid is set, load grant_q with the first set index searching ptr, ptr+1, ... and wrapping NUM_SOURCES-1 -> 0; enter GRANT.
REQ-016 GRANT: src_ready[g] = src_valid[g] & (!out_valid | out_ready); src_ready is 0 for all other indices and in IDLE.
REQ-017 On transfer from g: out_data <= src_data[g], out_src_id <= g, out_valid <= 1, ptr <= (g == NUM_SOURCES-1) ? 0 : g+1, grant_q <= 0, state <= IDLE.
REQ-018 The mandatory IDLE cycle after each transfer is the bus turnaround cycle; bus_en is all-zero for at least one cycle between any two grants.
REQ-019 GRANT with src_valid[g] == 0 (withdrawn request) -> IDLE, grant_q <= 0, ptr unchanged, no output update.
REQ-020 Grant is held (no re-arbitration) while src_valid[g] = 1 and the output register is stalled.
REQ-021 out_valid clears on out_valid & out_ready when no transfer occurs in the same cycle; on a simultaneous pop and transfer, out_valid stays 1 and the new word is loaded.
REQ-022 While out_valid & !out_ready, out_data and out_src_id are held stable.
REQ-023 Latency: src_valid rises in IDLE at cycle 0 -> bus_en/src_ready at cycle 1 -> out_valid at cycle 2; peak throughput is 1 word per 2 cycles.
REQ-024 bus_en has at most one bit set in every cycle, including the cycle leaving reset.

Reset
REQ-025 While reset_n = 0 at a clock edge: state = IDLE, grant_q = 0, ptr = 0, out_valid = 0, out_data = 0, out_src_id = 0.
REQ-026 Reset asserted mid-GRANT or with out_valid = 1 discards the grant and the held word; no transfer is reported for that cycle.

Structure
REQ-027 Package tri_bus_pkg holds the state enum (IDLE, GRANT) and the ID-width helper function.
REQ-028 Sub-module rr_arbiter (combinational): inputs request vector and ptr, output one-hot grant and grant index; instantiated once.

Verification (NUM_SOURCES=4, DATA_WIDTH=8)
REQ-029 Single request: src_valid=0100, src_data[2]=0xA5, out_ready=1 -> bus_en=0100 at cycle 1, out_valid=1, out_data=0xA5, out_src_id=2 at cycle 2.
REQ-030 All requesting from reset: src_valid=1111 held -> grants in order 0,1,2,3,0, separated by one all-zero bus_en cycle each.
REQ-031 Wrap: ptr=3, src_valid=1001 -> source 3 granted first, then source 0.
REQ-032 Backpressure: out_ready=0 with out_valid=1 -> src_ready=0, grant held, out_data stable; out_ready=1 -> pop and new load in the same cycle.
REQ-033 Withdraw: src_valid[1] drops during GRANT -> IDLE next cycle, no output, ptr unchanged.
REQ-034 Reset mid-GRANT with out_valid=1 -> next cycle bus_en=0, out_valid=0, ptr=0.
